imem_loader: RTL and testbench



---
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_loader.sv | 97 +++++++++
 tb/tb_imem_loader.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write port of the loader
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [7:0]            i_byte;
    logic                  i_valid;
    logic                  o_ready;
    logic                  i_start;
    logic                  o_mem_we;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_data;
    logic                  o_cpu_rst;
    logic                  o_done;
    logic                  o_err;
    modport master (
        output i_byte, i_valid, i_start,
        input  o_ready, o_mem_we, o_mem_addr, o_mem_data, o_cpu_rst, o_done, o_err
    );
    modport slave (
        input  i_byte, i_valid, i_start,
        output o_ready, o_mem_we, o_mem_addr, o_mem_data, o_cpu_rst, o_done, o_err
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles a length-prefixed big-endian byte stream into instruction memory words
module imem_loader #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int ROM_BLOCKS_NUM = 2**10
) (
    input  logic           i_clk,
    input  logic           i_rst,
    imem_loader_if.slave   bus
);
    typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, DONE, ERR} state_t;
    state_t                state;
    logic [1:0]            cnt;
    logic [15:0]           n;
    logic [ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic [15:0]           n_new;
    logic [DATA_WIDTH-1:0] word;
    assign n_new = {n[15:8], bus.i_byte};
    assign word  = {shreg[DATA_WIDTH-9:0], bus.i_byte};
    // load FSM; all outputs are registered and updated together with the state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= LEN_HI;
            cnt            <= '0;
            n              <= '0;
            idx            <= '0;
            shreg          <= '0;
            bus.o_ready    <= 1'b1;
            bus.o_mem_we   <= 1'b0;
            bus.o_mem_addr <= '0;
            bus.o_mem_data <= '0;
            bus.o_cpu_rst  <= 1'b1;
            bus.o_done     <= 1'b0;
            bus.o_err      <= 1'b0;
        end else begin
            bus.o_mem_we <= 1'b0;
            case (state)
                LEN_HI: if (bus.i_valid) begin
                    n[15:8] <= bus.i_byte;
                    state   <= LEN_LO;
                end
                LEN_LO: if (bus.i_valid) begin
                    n[7:0] <= bus.i_byte;
                    idx    <= '0;
                    cnt    <= '0;
                    if (n_new == 16'd0) begin
                        state         <= DONE;
                        bus.o_ready   <= 1'b0;
                        bus.o_done    <= 1'b1;
                        bus.o_cpu_rst <= 1'b0;
                    end else if (32'(n_new) > 32'(ROM_BLOCKS_NUM)) begin
                        state       <= ERR;
                        bus.o_ready <= 1'b0;
                        bus.o_err   <= 1'b1;
                    end else begin
                        state <= DATA;
                    end
                end
                DATA: if (idx == ADDR_WIDTH'(n)) begin
                    // last word's write strobe is on the bus this cycle; release the core after it
                    state         <= DONE;
                    bus.o_ready   <= 1'b0;
                    bus.o_done    <= 1'b1;
                    bus.o_cpu_rst <= 1'b0;
                end else if (bus.i_valid) begin
                    shreg <= word;
                    cnt   <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        bus.o_mem_we   <= 1'b1;
                        bus.o_mem_addr <= idx;
                        bus.o_mem_data <= word;
                        idx            <= idx + 1'b1;
                    end
                end
                DONE: if (bus.i_start) begin
                    state         <= LEN_HI;
                    idx           <= '0;
                    cnt           <= '0;
                    n             <= '0;
                    bus.o_ready   <= 1'b1;
                    bus.o_done    <= 1'b0;
                    bus.o_cpu_rst <= 1'b1;
                end
                ERR: if (bus.i_start) begin
                    state       <= LEN_HI;
                    idx         <= '0;
                    cnt         <= '0;
                    n           <= '0;
                    bus.o_ready <= 1'b1;
                    bus.o_err   <= 1'b0;
                end
                default: state <= LEN_HI;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized stream stimulus checked each cycle against a byte-count model
module tb_imem_loader;
    localparam int ROM = 1024;
    logic i_clk = 1'b0;
    logic i_rst;
    int total = 0;
    int passed = 0;
    imem_loader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();
    imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ROM_BLOCKS_NUM(ROM)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus(bus)
    );
    // free-running clock
    always #5 i_clk = ~i_clk;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask
    int          m_cnt = 0;
    int          m_n = 0;
    bit          m_done = 0, m_err = 0, m_fin = 0, m_we = 0;
    logic [31:0] m_addr = 0, m_data = 0, m_word = 0;
    // model: position in the current load is the number of bytes accepted so far
    always @(posedge i_clk) begin
        m_we = 0;
        if (i_rst) begin
            m_cnt = 0; m_n = 0; m_done = 0; m_err = 0; m_fin = 0;
            m_addr = 0; m_data = 0; m_word = 0;
        end else if (m_done || m_err) begin
            if (bus.i_start) begin m_done = 0; m_err = 0; m_cnt = 0; end
        end else if (m_fin) begin
            m_fin = 0; m_done = 1;
        end else if (bus.i_valid) begin
            m_cnt++;
            if (m_cnt == 1) m_n = int'(bus.i_byte) * 256;
            else if (m_cnt == 2) begin
                m_n += int'(bus.i_byte);
                if (m_n == 0) m_done = 1;
                else if (m_n > ROM) m_err = 1;
            end else begin
                m_word = {m_word[23:0], bus.i_byte};
                if ((m_cnt - 2) % 4 == 0) begin
                    m_we = 1;
                    m_addr = (m_cnt - 2) / 4 - 1;
                    m_data = m_word;
                    if (int'(m_addr) == m_n - 1) m_fin = 1;
                end
            end
        end
    end
    // compare every cycle shortly after the edge
    always @(posedge i_clk) begin
        #1;
        chk("ready", bus.o_ready, !(m_done || m_err));
        chk("mem_we", bus.o_mem_we, m_we);
        chk("cpu_rst", bus.o_cpu_rst, !m_done);
        chk("done", bus.o_done, m_done);
        chk("err", bus.o_err, m_err);
        if (m_we) begin
            chk("mem_addr", bus.o_mem_addr, m_addr);
            chk("mem_data", bus.o_mem_data, m_data);
        end
    end
    logic [63:0] dut_w[$];
    // record every write the memory would capture
    always @(posedge i_clk) if (bus.o_mem_we === 1'b1) dut_w.push_back({bus.o_mem_addr, bus.o_mem_data});
    task automatic send(input logic [7:0] b, input int gap);
        bit ok = 0;
        bus.i_valid = 1'b0;
        repeat (gap) @(negedge i_clk);
        bus.i_byte = b;
        bus.i_valid = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(posedge i_clk);
            if (bus.o_ready === 1'b1) ok = 1;
        end
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        if (!ok) begin
            $display("FAIL send_timeout: got ready=0 expected ready=1");
            $fatal(1);
        end
    endtask
    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 3; i >= 0; i--) send(w[i*8 +: 8], $urandom_range(0, maxgap));
    endtask
    task automatic pulse_start();
        bus.i_start = 1'b1;
        @(negedge i_clk);
        bus.i_start = 1'b0;
    endtask
    task automatic wait_done();
        for (int t = 0; t < 10 && bus.o_done !== 1'b1; t++) @(negedge i_clk);
        chk("wait_done", bus.o_done, 1'b1);
    endtask
    initial begin
        int w0;
        i_rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_start = 1'b0;
        bus.i_byte = 8'h00;
        repeat (2) @(negedge i_clk);
        chk("rst_ready", bus.o_ready, 1'b1);
        chk("rst_we", bus.o_mem_we, 1'b0);
        chk("rst_addr", bus.o_mem_addr, 32'h0);
        chk("rst_data", bus.o_mem_data, 32'h0);
        chk("rst_cpu_rst", bus.o_cpu_rst, 1'b1);
        chk("rst_done", bus.o_done, 1'b0);
        chk("rst_err", bus.o_err, 1'b0);
        i_rst = 1'b0;
        // two words at full rate
        send(8'h00, 0); send(8'h02, 0);
        send_word(32'hDEADBEEF, 0); send_word(32'h01234567, 0);
        wait_done();
        chk("fr_count", dut_w.size(), 2);
        chk("fr_w0", dut_w[0], {32'd0, 32'hDEADBEEF});
        chk("fr_w1", dut_w[1], {32'd1, 32'h01234567});
        chk("fr_cpu_rst", bus.o_cpu_rst, 1'b0);
        // same stream with idle gaps
        pulse_start();
        send(8'h00, $urandom_range(0, 3)); send(8'h02, $urandom_range(0, 3));
        send_word(32'hDEADBEEF, 3); send_word(32'h01234567, 3);
        wait_done();
        chk("gap_count", dut_w.size(), 4);
        chk("gap_w0", dut_w[2], {32'd0, 32'hDEADBEEF});
        chk("gap_w1", dut_w[3], {32'd1, 32'h01234567});
        // empty image
        pulse_start();
        send(8'h00, 0); send(8'h00, 0);
        chk("n0_done", bus.o_done, 1'b1);
        chk("n0_cpu_rst", bus.o_cpu_rst, 1'b0);
        chk("n0_count", dut_w.size(), 4);
        // oversize image
        pulse_start();
        send(8'h04, 0); send(8'h01, 0);
        chk("err_flag", bus.o_err, 1'b1);
        chk("err_ready", bus.o_ready, 1'b0);
        chk("err_cpu_rst", bus.o_cpu_rst, 1'b1);
        repeat (3) @(negedge i_clk);
        chk("err_count", dut_w.size(), 4);
        pulse_start();
        chk("err_clear", bus.o_err, 1'b0);
        chk("err_rearm_ready", bus.o_ready, 1'b1);
        // reset in the middle of a word
        send(8'h00, 0); send(8'h01, 0); send(8'hAA, 0); send(8'hBB, 0);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        send(8'h00, 0); send(8'h01, 0); send_word(32'h11223344, 0);
        wait_done();
        chk("abort_count", dut_w.size(), 5);
        chk("abort_w", dut_w[4], {32'd0, 32'h11223344});
        // full-depth image, data equals index
        pulse_start();
        send(8'h04, 0); send(8'h00, 0);
        for (int i = 0; i < ROM; i++) send_word(32'(i), 0);
        wait_done();
        chk("full_count", dut_w.size(), 5 + ROM);
        chk("full_last", dut_w[$], {32'h3FF, 32'h3FF});
        // start with a byte presented: start wins, byte dropped
        bus.i_byte = 8'h55;
        bus.i_valid = 1'b1;
        pulse_start();
        bus.i_valid = 1'b0;
        chk("sv_done", bus.o_done, 1'b0);
        chk("sv_ready", bus.o_ready, 1'b1);
        send(8'h00, 0); send(8'h01, 0); send_word(32'hCAFEBABE, 0);
        wait_done();
        chk("sv_w", dut_w[$], {32'd0, 32'hCAFEBABE});
        // random loads, some oversize
        for (int r = 0; r < 8; r++) begin
            int n;
            n = ($urandom_range(0, 3) == 0) ? ROM + 1 + $urandom_range(0, 3000) : $urandom_range(0, 6);
            pulse_start();
            send(8'(n >> 8), $urandom_range(0, 3)); send(8'(n), $urandom_range(0, 3));
            if (n <= ROM) for (int i = 0; i < n; i++) send_word($urandom, 3);
            repeat (3) @(negedge i_clk);
            chk("rand_end", bus.o_done | bus.o_err, 1'b1);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
